// File: rtl/ram8_burst_ctrl_pkg.sv
// Shared types and constants for the RAM8 burst sequencer.
// Optional FILL support is selected with the RAM8_BURST_FILL_EN macro.
package ram8_burst_pkg;

    localparam int RAM_ADDR_W = 3;
    localparam int RAM_DATA_W = 8;

    // Command opcodes as carried on cmd_op
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Sequencer states; the controller stores these as plain 3-bit codes
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_FILL     = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RD_HOLD  = 3'd5
    } state_e;

    // Next word address with wrap-around across the 8-word macro
    function automatic logic [RAM_ADDR_W-1:0] next_addr(input logic [RAM_ADDR_W-1:0] a);
        return a + RAM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram8_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream and RAM8 macro signals.
// slave: the burst controller; master: whoever issues commands and owns the macro model.
interface ram8_burst_ctrl_if
    import ram8_burst_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_fill;
    // Write byte stream
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    // Read byte stream
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    // Status
    logic              busy;
    // RAM8 macro port
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill,
        output cmd_ready,
        input  wdata_valid, wdata,
        output wdata_ready,
        output rdata_valid, rdata,
        input  rdata_ready,
        output busy,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_do
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill,
        input  cmd_ready,
        output wdata_valid, wdata,
        input  wdata_ready,
        input  rdata_valid, rdata,
        output rdata_ready,
        input  busy,
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_do
    );

endinterface

// File: rtl/ram8_burst_ctrl.sv
// Burst sequencer for the 8x8 RAM8 macro: sole driver of its single port.
// FILL bursts are built only when RAM8_BURST_FILL_EN is defined; otherwise
// a FILL command is swallowed like the reserved opcode.
module ram8_burst_ctrl
    import ram8_burst_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram8_burst_ctrl_if.slave      bus
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_WRITE    = ST_WRITE;
    localparam logic [2:0] S_FILL     = ST_FILL;
    localparam logic [2:0] S_RD_ISSUE = ST_RD_ISSUE;
    localparam logic [2:0] S_RD_CAP   = ST_RD_CAP;
    localparam logic [2:0] S_RD_HOLD  = ST_RD_HOLD;

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remain_q,   remain_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
`ifdef RAM8_BURST_FILL_EN
    logic [DATA_W-1:0] fill_q,     fill_d;
`else
    // Fill byte has no consumer when FILL is not built
    logic unused_fill;
    assign unused_fill = ^bus.cmd_fill;
`endif

    logic last_word;
    assign last_word = (remain_q == '0);

    // Next-state, address/length counters and read-capture register
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        rdata_d    = rdata_q;
`ifdef RAM8_BURST_FILL_EN
        fill_d     = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cur_addr_d = bus.cmd_addr;
                    remain_d   = bus.cmd_len;
`ifdef RAM8_BURST_FILL_EN
                    fill_d     = bus.cmd_fill;
`endif
                    case (bus.cmd_op)
                        OP_WRITE: state_d = S_WRITE;
                        OP_READ:  state_d = S_RD_ISSUE;
`ifdef RAM8_BURST_FILL_EN
                        OP_FILL:  state_d = S_FILL;
`endif
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WRITE: begin
                if (bus.wdata_valid) begin
                    cur_addr_d = next_addr(cur_addr_q);
                    if (last_word) state_d  = S_IDLE;
                    else           remain_d = remain_q - ADDR_W'(1);
                end
            end
`ifdef RAM8_BURST_FILL_EN
            S_FILL: begin
                cur_addr_d = next_addr(cur_addr_q);
                if (last_word) state_d  = S_IDLE;
                else           remain_d = remain_q - ADDR_W'(1);
            end
`endif
            S_RD_ISSUE: state_d = S_RD_CAP;
            S_RD_CAP: begin
                // Macro output is valid the cycle after the read access
                rdata_d = bus.ram_do;
                state_d = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (bus.rdata_ready) begin
                    if (last_word) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d = next_addr(cur_addr_q);
                        remain_d   = remain_q - ADDR_W'(1);
                        state_d    = S_RD_CAP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Macro port drive; idle values are all-zero
    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_di   = '0;
        case (state_q)
            S_WRITE: begin
                if (bus.wdata_valid) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_we   = 1'b1;
                    bus.ram_addr = cur_addr_q;
                    bus.ram_di   = bus.wdata;
                end
            end
`ifdef RAM8_BURST_FILL_EN
            S_FILL: begin
                bus.ram_en   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = cur_addr_q;
                bus.ram_di   = fill_q;
            end
`endif
            S_RD_ISSUE: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = cur_addr_q;
            end
            S_RD_HOLD: begin
                // Reissue in the handshake cycle keeps throughput at 1 byte / 2 cycles
                if (bus.rdata_ready && !last_word) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = next_addr(cur_addr_q);
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            rdata_q    <= '0;
`ifdef RAM8_BURST_FILL_EN
            fill_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            rdata_q    <= rdata_d;
`ifdef RAM8_BURST_FILL_EN
            fill_q     <= fill_d;
`endif
        end
    end

    // cmd_ready is held low while reset is asserted
    assign bus.cmd_ready   = rst_n && (state_q == S_IDLE);
    assign bus.wdata_ready = (state_q == S_WRITE);
    assign bus.rdata_valid = (state_q == S_RD_HOLD);
    assign bus.rdata       = rdata_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram8_burst_ctrl.sv
// Self-checking bench for ram8_burst_ctrl with a behavioural RAM8 (1-cycle read latency)
// and a reference memory image updated from the burst rules.
// Honours RAM8_BURST_FILL_EN the same way as the design.
module tb_ram8_burst_ctrl;
    import ram8_burst_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram8_burst_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    ram8_burst_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM8 macro
    logic [7:0] ram_mem [8];
    logic [7:0] ram_do_q = 8'h00;
    int         wr_count = 0;
    int         rd_count = 0;
    assign bus.ram_do = ram_do_q;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                ram_mem[bus.ram_addr] <= bus.ram_di;
                wr_count <= wr_count + 1;
            end else begin
                ram_do_q <= ram_mem[bus.ram_addr];
                rd_count <= rd_count + 1;
            end
        end
    end

    // Reference image and expected access counts
    logic [7:0] ref_mem [8];
    int exp_wr   = 0;
    int exp_rd   = 0;
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int addr, input int len, input logic [7:0] fill);
        int t;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = 3'(addr);
        bus.cmd_len   = 3'(len);
        bus.cmd_fill  = fill;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 3'($urandom);
        bus.cmd_len   = 3'($urandom);
        $display("cmd op=%0d addr=%0d len=%0d fill=%02h accepted", op, addr, len, fill);
    endtask

    task automatic write_burst(input int addr, input int len, input bit rnd, input logic [7:0] base,
                               input int gap_lo, input int gap_hi);
        logic [7:0] b;
        int a;
        int gap;
        for (int i = 0; i <= len; i++) begin
            a   = (addr + i) % 8;
            b   = rnd ? 8'($urandom) : base + 8'(i);
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
                bus.wdata_valid = 1'b0;
                bus.wdata       = 8'($urandom);
                @(negedge clk);
                chk("wr_gap_en", bus.ram_en, 0);
                chk("wr_gap_ready", bus.wdata_ready, 1);
                chk("wr_gap_cmd_ready", bus.cmd_ready, 0);
                @(posedge clk); #1;
            end
            bus.wdata_valid = 1'b1;
            bus.wdata       = b;
            @(negedge clk);
            chk("wr_ready", bus.wdata_ready, 1);
            chk("wr_en", {bus.ram_en, bus.ram_we}, 2'b11);
            chk("wr_addr", bus.ram_addr, a);
            chk("wr_di", bus.ram_di, b);
            chk("wr_cmd_ready", bus.cmd_ready, 0);
            @(posedge clk); #1;
            ref_mem[a] = b;
            exp_wr++;
            $display("write addr=%0d data=%02h", a, b);
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        chk("wr_done_busy", bus.busy, 0);
        chk("wr_done_cmd_ready", bus.cmd_ready, 1);
        chk("wr_done_en", bus.ram_en, 0);
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input int addr, input int len, input int st_lo, input int st_hi);
        logic [7:0] e;
        int c;
        int s;
        for (int i = 0; i <= len; i++) begin
            e = ref_mem[(addr + i) % 8];
            c = 1;
            @(negedge clk);
            if (i == 0) begin
                chk("rd_issue_en", {bus.ram_en, bus.ram_we}, 2'b10);
                chk("rd_issue_addr", bus.ram_addr, addr);
            end
            while (!bus.rdata_valid && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk("rd_latency", c, (i == 0) ? 3 : 2);
            chk("rd_data", bus.rdata, e);
            s = $urandom_range(st_hi, st_lo);
            for (int k = 0; k < s; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("rd_stall_valid", bus.rdata_valid, 1);
                chk("rd_stall_data", bus.rdata, e);
                chk("rd_stall_en", bus.ram_en, 0);
            end
            bus.rdata_ready = 1'b1;
            #1;
            chk("rd_reissue_en", bus.ram_en, (i != len));
            if (i != len) begin
                chk("rd_reissue_addr", bus.ram_addr, (addr + i + 1) % 8);
                chk("rd_reissue_we", bus.ram_we, 0);
            end
            @(posedge clk); #1;
            bus.rdata_ready = 1'b0;
            exp_rd++;
            $display("read addr=%0d data=%02h stall=%0d", (addr + i) % 8, e, s);
        end
        @(negedge clk);
        chk("rd_done_busy", bus.busy, 0);
        chk("rd_done_cmd_ready", bus.cmd_ready, 1);
        chk("rd_done_valid", bus.rdata_valid, 0);
        @(posedge clk); #1;
    endtask

    // Reserved (or disabled FILL) command: consumed, no access, write bytes ignored
    task automatic nop_cmd(input logic [1:0] op, input int addr, input int len);
        send_cmd(op, addr, len, 8'($urandom));
        bus.wdata_valid = 1'b1;
        bus.wdata       = 8'($urandom);
        @(negedge clk);
        chk("nop_busy", bus.busy, 0);
        chk("nop_cmd_ready", bus.cmd_ready, 1);
        chk("nop_en", bus.ram_en, 0);
        chk("nop_wdata_ready", bus.wdata_ready, 0);
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
        chk("nop_wr_count", wr_count, exp_wr);
    endtask

`ifdef RAM8_BURST_FILL_EN
    task automatic fill_burst(input int addr, input int len, input logic [7:0] f);
        send_cmd(OP_FILL, addr, len, f);
        bus.wdata_valid = 1'b1;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            chk("fill_en", {bus.ram_en, bus.ram_we}, 2'b11);
            chk("fill_addr", bus.ram_addr, (addr + i) % 8);
            chk("fill_di", bus.ram_di, f);
            chk("fill_wdata_ready", bus.wdata_ready, 0);
            @(posedge clk); #1;
            ref_mem[(addr + i) % 8] = f;
            exp_wr++;
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        chk("fill_done_busy", bus.busy, 0);
        @(posedge clk); #1;
    endtask
`endif

    task automatic check_mem(input string tag);
        for (int a = 0; a < 8; a++) chk(tag, ram_mem[a], ref_mem[a]);
        $display("memory image compared (%s)", tag);
    endtask

    initial begin
        int c;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.cmd_fill    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.ram_en, 0);
        chk("rst_rvalid", bus.rdata_valid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_wready", bus.wdata_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;

        // Full write then full read at top speed
        send_cmd(OP_WRITE, 0, 7, 8'h00);
        write_burst(0, 7, 1'b0, 8'h10, 0, 0);
        send_cmd(OP_READ, 0, 7, 8'h00);
        read_burst(0, 7, 0, 0);

        // Wrapping write: 6,7,0,1
        send_cmd(OP_WRITE, 6, 3, 8'h00);
        write_burst(6, 3, 1'b0, 8'hA0, 0, 0);
        check_mem("wrap_mem");

        // Read with consumer stalled 5 cycles per byte
        send_cmd(OP_READ, 2, 1, 8'h00);
        read_burst(2, 1, 5, 5);

        // Write with 3-cycle valid gaps
        send_cmd(OP_WRITE, 3, 2, 8'h00);
        write_burst(3, 2, 1'b1, 8'h00, 3, 3);
        chk("wr_count_directed", wr_count, exp_wr);

        // Reserved opcode
        nop_cmd(OP_RSVD, 5, 4);

        // Optional FILL
`ifdef RAM8_BURST_FILL_EN
        fill_burst(4, 7, 8'h5A);
`else
        nop_cmd(OP_FILL, 4, 7);
`endif
        check_mem("fill_mem");

        // Reset asserted while a read burst is holding data with a reissue pending
        send_cmd(OP_READ, 0, 3, 8'h00);
        c = 0;
        @(negedge clk);
        while (!bus.rdata_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("mid_rst_valid_seen", bus.rdata_valid, 1);
        bus.rdata_ready = 1'b1;
        #1;
        chk("mid_rst_en_before", bus.ram_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", bus.ram_en, 0);
        chk("mid_rst_rvalid", bus.rdata_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        bus.rdata_ready = 1'b0;
        exp_rd++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        $display("reset during read burst done");

        // Randomized bursts against the reference image
        for (int n = 0; n < 24; n++) begin
            logic [1:0] op;
            int a;
            int l;
            op = 2'($urandom_range(3, 0));
            a  = $urandom_range(7, 0);
            l  = $urandom_range(7, 0);
            case (op)
                2'b00: begin
                    send_cmd(op, a, l, 8'h00);
                    write_burst(a, l, 1'b1, 8'h00, 0, 2);
                end
                2'b01: begin
                    send_cmd(op, a, l, 8'h00);
                    read_burst(a, l, 0, 2);
                end
`ifdef RAM8_BURST_FILL_EN
                2'b10: fill_burst(a, l, 8'($urandom));
`endif
                default: nop_cmd(op, a, l);
            endcase
        end
        check_mem("final_mem");
        chk("final_wr_count", wr_count, exp_wr);
        chk("final_rd_count", rd_count, exp_rd);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
